// File: rtl/shift_sequencer_if.sv
// Control/handshake bundle between the main control unit and the shift sequencer.
// The master drives the request side; the slave returns the Y/shifter strobes and status.
interface shift_sequencer_if #(
   parameter int AMT_W = 4
);
   logic             start;
   logic             dir;
   logic [AMT_W-1:0] amount;
   logic             use_offset;
   logic             abort;
   logic             Y_in;
   logic             Y_offset_in;
   logic             Y_out;
   logic             Y_shift_left;
   logic             Y_shift_right;
   logic [1:0]       shift_amount;
   logic             shifter_to_bus;
   logic             busy;
   logic             done;

   modport master (
      output start, dir, amount, use_offset, abort,
      input  Y_in, Y_offset_in, Y_out, Y_shift_left, Y_shift_right,
             shift_amount, shifter_to_bus, busy, done
   );

   modport slave (
      input  start, dir, amount, use_offset, abort,
      output Y_in, Y_offset_in, Y_out, Y_shift_left, Y_shift_right,
             shift_amount, shifter_to_bus, busy, done
   );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences Y and the barrel shifter to shift 0..2^AMT_W-1 positions, at most STEP_MAX per pass.
// Optional SHIFT_SEQ_ABORT_EN makes abort cancel an operation in LOAD or SHIFT.
module shift_sequencer #(
   parameter int AMT_W    = 4,
   parameter int STEP_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   shift_sequencer_if.slave  sif
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

   localparam logic [AMT_W-1:0] STEP_MAX_W = AMT_W'(STEP_MAX);

   state_e           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             uo_q, uo_d;
   logic [1:0]       step;
   logic [AMT_W-1:0] rem_after;
   logic             abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
   assign abort_hit = sif.abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Clamp avoids underflow: the last pass only takes what is left.
   assign step      = (rem_q > STEP_MAX_W) ? 2'(STEP_MAX) : rem_q[1:0];
   assign rem_after = rem_q - AMT_W'(step);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         uo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         uo_q    <= uo_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      rem_d              = rem_q;
      dir_d              = dir_q;
      uo_d               = uo_q;
      sif.Y_in           = 1'b0;
      sif.Y_offset_in    = 1'b0;
      sif.Y_out          = 1'b0;
      sif.Y_shift_left   = 1'b0;
      sif.Y_shift_right  = 1'b0;
      sif.shift_amount   = 2'd0;
      sif.shifter_to_bus = 1'b0;
      sif.busy           = 1'b0;
      sif.done           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sif.start) begin
               dir_d   = sif.dir;
               rem_d   = sif.amount;
               uo_d    = sif.use_offset;
               state_d = LOAD;
            end
         end
         LOAD: begin
            sif.busy        = 1'b1;
            sif.Y_offset_in = uo_q;
            sif.Y_in        = ~uo_q;
            if (abort_hit) begin
               rem_d   = '0;
               state_d = IDLE;
            end else begin
               state_d = (rem_q != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // Shifter result goes straight back into Y over the bus in the same cycle.
            sif.busy           = 1'b1;
            sif.shift_amount   = step;
            sif.Y_shift_left   = ~dir_q;
            sif.Y_shift_right  = dir_q;
            sif.shifter_to_bus = 1'b1;
            sif.Y_in           = 1'b1;
            if (abort_hit) begin
               rem_d   = '0;
               state_d = IDLE;
            end else begin
               rem_d   = rem_after;
               state_d = (rem_after != '0) ? SHIFT : DONE;
            end
         end
         DONE: begin
            sif.busy  = 1'b1;
            sif.done  = 1'b1;
            sif.Y_out = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
